// File: rtl/m_ctrl_fsm_if.sv
// Control-unit <-> multi-cycle datapath bundle: IR/flag/ready inputs to the controller and every control strobe back.
// master = control unit, slave = datapath/memory side.
interface m_ctrl_fsm_if #(
  parameter int unsigned ST_W = 5
);
  logic [31:0]     Inst;
  logic            zero;
  logic            MIO_ready;

  logic            MemRead;
  logic            MemWrite;
  logic            IorD;
  logic            IRWrite;
  logic [1:0]      RegDst;
  logic            RegWrite;
  logic [1:0]      MemtoReg;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      PCSource;
  logic            PCWrite;
  logic            PCWriteCond;
  logic            Branch;
  logic [2:0]      ALU_operation;
  logic            illegal;
  logic [ST_W-1:0] state;

  modport master (
    input  Inst, zero, MIO_ready,
    output MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch,
           ALU_operation, illegal, state
  );

  modport slave (
    output Inst, zero, MIO_ready,
    input  MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch,
           ALU_operation, illegal, state
  );
endinterface

// File: rtl/m_ctrl_fsm.sv
// Multi-cycle MIPS control unit (Moore FSM). State encoding is sequential from IF=0 in the enum order below.
// Optional ILLEGAL_TRAP_EN: illegal instructions lock into an absorbing ERR state; otherwise they execute as NOPs.
module m_ctrl_fsm #(
  parameter int unsigned ST_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  m_ctrl_fsm_if.master bus
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'h00;
  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW   = 6'h23;
  localparam logic [OP_W-1:0] OP_SW   = 6'h2B;

  localparam logic [OP_W-1:0] FN_JR  = 6'h08;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b011;
  localparam logic [ALU_W-1:0] ALU_NOR = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [ST_W-1:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_EX_MEM, S_MEM_RD, S_WB_LW, S_MEM_WR,
    S_EX_BEQ, S_EX_BNE, S_EX_J, S_EX_JAL, S_JR, S_EX_I, S_WB_I, S_EX_LUI,
    S_ERR
  } state_t;
`else
  typedef enum logic [ST_W-1:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_EX_MEM, S_MEM_RD, S_WB_LW, S_MEM_WR,
    S_EX_BEQ, S_EX_BNE, S_EX_J, S_EX_JAL, S_JR, S_EX_I, S_WB_I, S_EX_LUI
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  state_t            w_id_next;
  state_t            w_bad_next;
  logic [OP_W-1:0]   w_op;
  logic [OP_W-1:0]   w_fn;
  logic [ALU_W-1:0]  w_r_alu;
  logic [ALU_W-1:0]  w_i_alu;
  logic              w_r_ok;
  logic              w_unused;

  assign w_op     = bus.Inst[31:26];
  assign w_fn     = bus.Inst[5:0];
  // zero is consumed by the datapath's branch gating; the controller only observes it.
  assign w_unused = ^{bus.zero, bus.Inst[25:6]};

`ifdef ILLEGAL_TRAP_EN
  assign w_bad_next = S_ERR;
`else
  assign w_bad_next = S_IF;
`endif

  // R-type funct and I-type opcode to ALU operation
  always_comb begin
    w_r_alu = ALU_ADD;
    w_r_ok  = 1'b1;
    case (w_fn)
      FN_ADD:  w_r_alu = ALU_ADD;
      FN_SUB:  w_r_alu = ALU_SUB;
      FN_AND:  w_r_alu = ALU_AND;
      FN_OR:   w_r_alu = ALU_OR;
      FN_XOR:  w_r_alu = ALU_XOR;
      FN_NOR:  w_r_alu = ALU_NOR;
      FN_SLT:  w_r_alu = ALU_SLT;
      FN_JR:   w_r_alu = ALU_ADD;
      default: w_r_ok  = 1'b0;
    endcase

    w_i_alu = ALU_ADD;
    case (w_op)
      OP_SLTI: w_i_alu = ALU_SLT;
      OP_ANDI: w_i_alu = ALU_AND;
      OP_ORI:  w_i_alu = ALU_OR;
      OP_XORI: w_i_alu = ALU_XOR;
      default: w_i_alu = ALU_ADD;
    endcase
  end

  // Instruction decode target out of ID
  always_comb begin
    w_id_next = w_bad_next;
    case (w_op)
      OP_R: begin
        if (w_fn == FN_JR)  w_id_next = S_JR;
        else if (w_r_ok)    w_id_next = S_EX_R;
        else                w_id_next = w_bad_next;
      end
      OP_LW, OP_SW:                                w_id_next = S_EX_MEM;
      OP_BEQ:                                      w_id_next = S_EX_BEQ;
      OP_BNE:                                      w_id_next = S_EX_BNE;
      OP_J:                                        w_id_next = S_EX_J;
      OP_JAL:                                      w_id_next = S_EX_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:  w_id_next = S_EX_I;
      OP_LUI:                                      w_id_next = S_EX_LUI;
      default:                                     w_id_next = w_bad_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next            = S_IF;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IorD          = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegDst        = 2'd0;
    bus.RegWrite      = 1'b0;
    bus.MemtoReg      = 2'd0;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrcB       = 2'd0;
    bus.PCSource      = 2'd0;
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.Branch        = 1'b0;
    bus.ALU_operation = ALU_ADD;
    bus.illegal       = 1'b0;

    case (r_state)
      S_IF: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.PCWrite = 1'b1;
        bus.IRWrite = bus.MIO_ready;
        w_next      = bus.MIO_ready ? S_ID : S_IF;
      end
      S_ID: begin
        bus.ALUSrcB = 2'd3;
        w_next      = w_id_next;
      end
      S_EX_R: begin
        bus.ALUSrcA       = 1'b1;
        bus.ALU_operation = w_r_alu;
        w_next            = S_WB_R;
      end
      S_WB_R: begin
        bus.RegDst   = 2'd1;
        bus.RegWrite = 1'b1;
        w_next       = S_IF;
      end
      S_EX_MEM: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        w_next      = (w_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        w_next      = bus.MIO_ready ? S_WB_LW : S_MEM_RD;
      end
      S_WB_LW: begin
        bus.MemtoReg = 2'd1;
        bus.RegWrite = 1'b1;
        w_next       = S_IF;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        w_next       = bus.MIO_ready ? S_IF : S_MEM_WR;
      end
      S_EX_BEQ, S_EX_BNE: begin
        bus.ALUSrcA       = 1'b1;
        bus.ALU_operation = ALU_SUB;
        bus.PCWriteCond   = 1'b1;
        bus.PCSource      = 2'd1;
        bus.Branch        = (r_state == S_EX_BEQ);
        w_next            = S_IF;
      end
      S_EX_J: begin
        bus.PCSource = 2'd2;
        bus.PCWrite  = 1'b1;
        w_next       = S_IF;
      end
      // $31 and PC share one edge, so the link register takes the fetched PC+4
      S_EX_JAL: begin
        bus.PCSource = 2'd2;
        bus.PCWrite  = 1'b1;
        bus.RegDst   = 2'd2;
        bus.MemtoReg = 2'd3;
        bus.RegWrite = 1'b1;
        w_next       = S_IF;
      end
      S_JR: begin
        bus.PCSource = 2'd3;
        bus.PCWrite  = 1'b1;
        w_next       = S_IF;
      end
      S_EX_I: begin
        bus.ALUSrcA       = 1'b1;
        bus.ALUSrcB       = 2'd2;
        bus.ALU_operation = w_i_alu;
        w_next            = S_WB_I;
      end
      S_WB_I: begin
        bus.RegWrite = 1'b1;
        w_next       = S_IF;
      end
      S_EX_LUI: begin
        bus.MemtoReg = 2'd2;
        bus.RegWrite = 1'b1;
        w_next       = S_IF;
      end
`ifdef ILLEGAL_TRAP_EN
      S_ERR: begin
        bus.illegal = 1'b1;
        w_next      = S_ERR;
      end
`endif
      default: w_next = S_IF;
    endcase
  end

  assign bus.state = r_state;

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// Directed bench for m_ctrl_fsm: per-instruction phase model drives a per-cycle compare, plus literal pins.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_m_ctrl_fsm;
  localparam int unsigned ST_W = 5;

  localparam int P_IF = 0, P_ID = 1, P_EX_R = 2, P_WB_R = 3, P_EX_MEM = 4, P_MEM_RD = 5,
                 P_WB_LW = 6, P_MEM_WR = 7, P_EX_BEQ = 8, P_EX_BNE = 9, P_EX_J = 10,
                 P_EX_JAL = 11, P_JR = 12, P_EX_I = 13, P_WB_I = 14, P_EX_LUI = 15, P_ERR = 16;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic [2:0] alu_op;
    logic       illegal;
    logic [4:0] state;
  } ctl_t;

  logic  clk = 1'b0;
  logic  reset;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string tag     = "init";
  ctl_t  exp_q[$];

  m_ctrl_fsm_if #(.ST_W(ST_W)) bus ();
  m_ctrl_fsm #(.ST_W(ST_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h26:   return 3'b011;
      6'h27:   return 3'b100;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] op);
    case (op)
      6'h0A:   return 3'b111;
      6'h0C:   return 3'b000;
      6'h0D:   return 3'b001;
      6'h0E:   return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Required control word for one cycle spent in phase ph
  function automatic ctl_t expect_ctl(input int ph, input logic [31:0] inst, input logic mio);
    ctl_t e;
    e        = '0;
    e.alu_op = 3'b010;
    e.state  = 5'(ph);
    case (ph)
      P_IF:     begin e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.pc_write = 1'b1; e.ir_write = mio; end
      P_ID:     e.alu_src_b = 2'd3;
      P_EX_R:   begin e.alu_src_a = 1'b1; e.alu_op = r_alu(inst[5:0]); end
      P_WB_R:   begin e.reg_dst = 2'd1; e.reg_write = 1'b1; end
      P_EX_MEM: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
      P_MEM_RD: begin e.mem_read = 1'b1; e.iord = 1'b1; end
      P_WB_LW:  begin e.mem_to_reg = 2'd1; e.reg_write = 1'b1; end
      P_MEM_WR: begin e.mem_write = 1'b1; e.iord = 1'b1; end
      P_EX_BEQ, P_EX_BNE: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'b110; e.pc_write_cond = 1'b1;
        e.pc_source = 2'd1; e.branch = (ph == P_EX_BEQ);
      end
      P_EX_J:   begin e.pc_source = 2'd2; e.pc_write = 1'b1; end
      P_EX_JAL: begin
        e.pc_source = 2'd2; e.pc_write = 1'b1; e.reg_dst = 2'd2;
        e.mem_to_reg = 2'd3; e.reg_write = 1'b1;
      end
      P_JR:     begin e.pc_source = 2'd3; e.pc_write = 1'b1; end
      P_EX_I:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_op = i_alu(inst[31:26]); end
      P_WB_I:   e.reg_write = 1'b1;
      P_EX_LUI: begin e.mem_to_reg = 2'd2; e.reg_write = 1'b1; end
      P_ERR:    e.illegal = 1'b1;
      default:  e = '0;
    endcase
    return e;
  endfunction

  function automatic ctl_t read_dut();
    ctl_t a;
    a.mem_read      = bus.MemRead;
    a.mem_write     = bus.MemWrite;
    a.iord          = bus.IorD;
    a.ir_write      = bus.IRWrite;
    a.reg_dst       = bus.RegDst;
    a.reg_write     = bus.RegWrite;
    a.mem_to_reg    = bus.MemtoReg;
    a.alu_src_a     = bus.ALUSrcA;
    a.alu_src_b     = bus.ALUSrcB;
    a.pc_source     = bus.PCSource;
    a.pc_write      = bus.PCWrite;
    a.pc_write_cond = bus.PCWriteCond;
    a.branch        = bus.Branch;
    a.alu_op        = bus.ALU_operation;
    a.illegal       = bus.illegal;
    a.state         = bus.state;
    return a;
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    ctl_t e;
    ctl_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = read_dut();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got %h required %h", tag, cyc, a, e);
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  task automatic step(input int ph, input logic [31:0] inst, input logic mio);
    bus.Inst      = inst;
    bus.MIO_ready = mio;
    bus.zero      = 1'($urandom_range(0, 1));
    exp_q.push_back(expect_ctl(ph, inst, mio));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic bad_instr(input logic [31:0] inst);
`ifdef ILLEGAL_TRAP_EN
    repeat (10) step(P_ERR, inst, 1'b1);
    reset = 1'b1;
    step(P_ERR, inst, 1'b1);
    reset = 1'b0;
`else
    pin({tag, "_nop_illegal"}, 32'(bus.illegal), 32'd0);
`endif
  endtask

  // One full instruction from fetch back to the next fetch
  task automatic run(input string nm, input logic [31:0] inst, input int if_stall,
                     input int mem_stall, output int cycles);
    int         c0;
    logic [5:0] op;
    logic [5:0] fn;
    c0  = cyc;
    tag = nm;
    op  = inst[31:26];
    fn  = inst[5:0];
    repeat (if_stall) step(P_IF, inst, 1'b0);
    step(P_IF, inst, 1'b1);
    step(P_ID, inst, 1'b1);
    case (op)
      6'h00: begin
        if (fn == 6'h08) step(P_JR, inst, 1'b1);
        else if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) begin
          step(P_EX_R, inst, 1'b1);
          step(P_WB_R, inst, 1'b1);
        end else bad_instr(inst);
      end
      6'h23: begin
        step(P_EX_MEM, inst, 1'b1);
        repeat (mem_stall) step(P_MEM_RD, inst, 1'b0);
        step(P_MEM_RD, inst, 1'b1);
        step(P_WB_LW, inst, 1'b1);
      end
      6'h2B: begin
        step(P_EX_MEM, inst, 1'b1);
        repeat (mem_stall) step(P_MEM_WR, inst, 1'b0);
        step(P_MEM_WR, inst, 1'b1);
      end
      6'h04: step(P_EX_BEQ, inst, 1'b1);
      6'h05: step(P_EX_BNE, inst, 1'b1);
      6'h02: step(P_EX_J, inst, 1'b1);
      6'h03: step(P_EX_JAL, inst, 1'b1);
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
        step(P_EX_I, inst, 1'b1);
        step(P_WB_I, inst, 1'b1);
      end
      6'h0F: step(P_EX_LUI, inst, 1'b1);
      default: bad_instr(inst);
    endcase
    cycles = cyc - c0;
  endtask

  initial begin
    int c;
    reset         = 1'b1;
    bus.Inst      = 32'h0;
    bus.zero      = 1'b0;
    bus.MIO_ready = 1'b1;
    @(posedge clk);
    #1;
    pin("rst_state",   32'(bus.state),   32'd0);
    pin("rst_pcwrite", 32'(bus.PCWrite), 32'd1);
    pin("rst_irwrite", 32'(bus.IRWrite), 32'd1);
    pin("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    pin("rst_regwr",   32'(bus.RegWrite), 32'd0);
    tag = "reset";
    step(P_IF, 32'h0, 1'b1);
    reset = 1'b0;

    run("add", 32'h00221820, 0, 0, c);  pin("lat_add", 32'(c), 32'd4);
    run("sub", 32'h00221822, 0, 0, c);
    run("and", 32'h00221824, 0, 0, c);
    run("or",  32'h00221825, 0, 0, c);
    run("xor", 32'h00221826, 0, 0, c);
    run("nor", 32'h00221827, 0, 0, c);
    run("slt", 32'h0022182A, 0, 0, c);
    run("add_ifstall", 32'h00221820, 2, 0, c); pin("lat_add_ifstall", 32'(c), 32'd6);
    run("lw_stall", 32'h8C220004, 0, 3, c);    pin("lat_lw_stall", 32'(c), 32'd8);
    run("lw",  32'h8C220004, 0, 0, c);         pin("lat_lw", 32'(c), 32'd5);
    run("sw_stall", 32'hAC220004, 0, 1, c);    pin("lat_sw_stall", 32'(c), 32'd5);

    tag = "beq";
    step(P_IF, 32'h10220003, 1'b1);
    step(P_ID, 32'h10220003, 1'b1);
    pin("beq_aluop",  32'(bus.ALU_operation), 32'h6);
    pin("beq_branch", 32'(bus.Branch),        32'd1);
    pin("beq_pcwc",   32'(bus.PCWriteCond),   32'd1);
    pin("beq_pcsrc",  32'(bus.PCSource),      32'd1);
    step(P_EX_BEQ, 32'h10220003, 1'b1);
    run("bne", 32'h14220003, 0, 0, c); pin("lat_bne", 32'(c), 32'd3);

    tag = "jal";
    step(P_IF, 32'h0C000010, 1'b1);
    step(P_ID, 32'h0C000010, 1'b1);
    pin("jal_regdst",   32'(bus.RegDst),   32'd2);
    pin("jal_memtoreg", 32'(bus.MemtoReg), 32'd3);
    pin("jal_pcsrc",    32'(bus.PCSource), 32'd2);
    step(P_EX_JAL, 32'h0C000010, 1'b1);
    run("j",    32'h08000010, 0, 0, c); pin("lat_j", 32'(c), 32'd3);
    run("jr",   32'h03E00008, 0, 0, c); pin("lat_jr", 32'(c), 32'd3);
    run("addi", 32'h20220005, 0, 0, c); pin("lat_addi", 32'(c), 32'd4);
    run("slti", 32'h28220005, 0, 0, c);
    run("andi", 32'h30220005, 0, 0, c);
    run("ori",  32'h34220005, 0, 0, c);
    run("xori", 32'h38220005, 0, 0, c);
    run("lui",  32'h3C010012, 0, 0, c); pin("lat_lui", 32'(c), 32'd3);

    run("bad_op",    32'hFC000000, 0, 0, c);
    run("bad_funct", 32'h00221821, 0, 0, c);

    tag = "sw_reset";
    step(P_IF,     32'hAC220004, 1'b1);
    step(P_ID,     32'hAC220004, 1'b1);
    step(P_EX_MEM, 32'hAC220004, 1'b1);
    step(P_MEM_WR, 32'hAC220004, 1'b0);
    reset = 1'b1;
    step(P_MEM_WR, 32'hAC220004, 1'b0);
    reset = 1'b0;
    pin("midrst_memwrite", 32'(bus.MemWrite), 32'd0);
    pin("midrst_state",    32'(bus.state),    32'd0);

    run("add_after", 32'h00221820, 1, 0, c);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
